// File: rtl/regbank_ar.sv
// General register bank with two tri-state read buses, one write port, an in-place
// inc/dec unit with Z/N/C flags, and a 2*DATA_WIDTH auto-incrementing address register.
module regbank_ar #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_BITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dbi,
  output logic [DATA_WIDTH-1:0] db,
  input  logic [ADDR_BITS-1:0]  dba,
  input  logic                  dbe,
  input  logic                  dbld,
  output logic [DATA_WIDTH-1:0] sb,
  input  logic [ADDR_BITS-1:0]  sba,
  input  logic                  sbe,
  input  logic                  incd,
  input  logic [ADDR_BITS-1:0]  ida,
  input  logic                  dec,
  output logic                  zf,
  output logic                  nf,
  output logic                  cf,
  input  logic                  arll,
  input  logic                  arhl,
  input  logic                  arinc,
  input  logic                  ral_adl,
  input  logic                  rah_adh,
  output logic [DATA_WIDTH-1:0] adl,
  output logic [DATA_WIDTH-1:0] adh,
  output logic                  arwrap
);

  localparam logic [DATA_WIDTH-1:0]   ONE    = DATA_WIDTH'(1);
  localparam logic [2*DATA_WIDTH-1:0] AR_ONE = (2*DATA_WIDTH)'(1);

  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  logic [2*DATA_WIDTH-1:0] ar_q, ar_d;
  logic                    zf_q, zf_d;
  logic                    nf_q, nf_d;
  logic                    cf_q, cf_d;
  logic                    arwrap_q, arwrap_d;

  logic [DATA_WIDTH-1:0]   inc_old;
  logic [DATA_WIDTH-1:0]   inc_res;
  logic                    inc_exec;
  logic                    ar_load;

  // A write to the same index takes priority; the inc/dec is then dropped entirely.
  assign inc_exec = incd && !(dbld && (dba == ida));
  assign inc_old  = regs_q[ida];
  assign inc_res  = dec ? (inc_old - ONE) : (inc_old + ONE);
  assign ar_load  = arll || arhl;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    zf_d = zf_q;
    nf_d = nf_q;
    cf_d = cf_q;
    if (inc_exec) begin
      regs_d[ida] = inc_res;
      zf_d        = (inc_res == '0);
      nf_d        = inc_res[DATA_WIDTH-1];
      cf_d        = dec ? (inc_old == '0) : (inc_old == '1);
    end
    if (dbld) begin
      regs_d[dba] = dbi;
    end
  end

  always_comb begin
    ar_d     = ar_q;
    arwrap_d = 1'b0;
    if (ar_load) begin
      if (arll) ar_d[DATA_WIDTH-1:0]            = dbi;
      if (arhl) ar_d[2*DATA_WIDTH-1:DATA_WIDTH] = dbi;
    end else if (arinc) begin
      ar_d     = ar_q + AR_ONE;
      arwrap_d = (ar_q == '1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      ar_q     <= '0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      cf_q     <= 1'b0;
      arwrap_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      ar_q     <= ar_d;
      zf_q     <= zf_d;
      nf_q     <= nf_d;
      cf_q     <= cf_d;
      arwrap_q <= arwrap_d;
    end
  end

  // Buses read stored state only; a same-cycle write is not bypassed.
  assign db  = dbe     ? regs_q[dba]                     : {DATA_WIDTH{1'bz}};
  assign sb  = sbe     ? regs_q[sba]                     : {DATA_WIDTH{1'bz}};
  assign adl = ral_adl ? ar_q[DATA_WIDTH-1:0]            : {DATA_WIDTH{1'bz}};
  assign adh = rah_adh ? ar_q[2*DATA_WIDTH-1:DATA_WIDTH] : {DATA_WIDTH{1'bz}};

  assign zf     = zf_q;
  assign nf     = nf_q;
  assign cf     = cf_q;
  assign arwrap = arwrap_q;

endmodule

// File: tb/tb_regbank_ar.sv
// Directed bench for regbank_ar: an integer-level model checked every falling edge,
// plus literal expectations at the points called out for the block.
module tb_regbank_ar;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dbi;
  logic [1:0] dba, sba, ida;
  logic       dbe, dbld, sbe, incd, dec;
  logic       arll, arhl, arinc, ral_adl, rah_adh;
  wire  [7:0] db, sb, adl, adh;
  wire        zf, nf, cf, arwrap;

  regbank_ar #(.DATA_WIDTH(8), .NUM_REGS(4), .ADDR_BITS(2)) dut (
    .clk(clk), .rst(rst), .dbi(dbi), .db(db), .dba(dba), .dbe(dbe), .dbld(dbld),
    .sb(sb), .sba(sba), .sbe(sbe), .incd(incd), .ida(ida), .dec(dec),
    .zf(zf), .nf(nf), .cf(cf), .arll(arll), .arhl(arhl), .arinc(arinc),
    .ral_adl(ral_adl), .rah_adh(rah_adh), .adl(adl), .adh(adh), .arwrap(arwrap)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  int m_regs [4];
  int m_ar;
  int m_zf, m_nf, m_cf, m_wrap;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_ar = 0; m_zf = 0; m_nf = 0; m_cf = 0; m_wrap = 0;
  endtask

  // Integer-level rules: values mod 256 for registers, mod 65536 for the address.
  task automatic model_step();
    int old, res;
    bit inc_ok;
    inc_ok = incd && !(dbld && dba == ida);
    if (inc_ok) begin
      old = m_regs[ida];
      res = dec ? (old + 255) % 256 : (old + 1) % 256;
      m_zf = (res == 0);
      m_nf = (res >= 128);
      m_cf = dec ? (old == 0) : (old == 255);
      m_regs[ida] = res;
    end
    if (dbld) m_regs[dba] = int'(dbi);
    m_wrap = 0;
    if (arll || arhl) begin
      if (arll) m_ar = (m_ar / 256) * 256 + int'(dbi);
      if (arhl) m_ar = int'(dbi) * 256 + (m_ar % 256);
    end else if (arinc) begin
      m_wrap = (m_ar == 65535);
      m_ar = (m_ar + 1) % 65536;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic idle();
    dbld = 0; incd = 0; dec = 0; arll = 0; arhl = 0; arinc = 0;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("db", int'(db), m_regs[dba]);
      chk("sb", int'(sb), m_regs[sba]);
      chk("adl", int'(adl), m_ar % 256);
      chk("adh", int'(adh), m_ar / 256);
      chk("zf", int'(zf), m_zf);
      chk("nf", int'(nf), m_nf);
      chk("cf", int'(cf), m_cf);
      chk("arwrap", int'(arwrap), m_wrap);
    end
  end

  initial begin
    rst = 0; dbi = 0; dba = 0; sba = 0; ida = 0;
    dbe = 1; sbe = 1; ral_adl = 1; rah_adh = 1;
    idle();
    model_reset();
    #12 rst = 1;
    cmp_en = 1;
    #1;
    chk("rst_db", int'(db), 8'h00);
    chk("rst_flags", int'({zf, nf, cf}), 0);
    chk("rst_arwrap", int'(arwrap), 0);

    // Write 0xA5 to r1; the write cycle still shows the old value.
    dba = 1; sba = 1; dbi = 8'hA5; dbld = 1;
    #1 chk("wr_old_db", int'(db), 8'h00);
    cyc(); idle();
    chk("wr_db", int'(db), 8'hA5);
    chk("wr_sb", int'(sb), 8'hA5);

    // r2 = 0xFF, then increment and decrement.
    dba = 2; dbi = 8'hFF; dbld = 1; cyc(); idle();
    incd = 1; ida = 2; dec = 0; cyc(); idle();
    chk("inc_val", int'(db), 8'h00);
    chk("inc_flags", int'({zf, nf, cf}), 3'b101);
    incd = 1; ida = 2; dec = 1; cyc(); idle();
    chk("dec_val", int'(db), 8'hFF);
    chk("dec_flags", int'({zf, nf, cf}), 3'b011);

    // Collision on the same index: write wins, flags hold.
    dba = 3; dbi = 8'h10; dbld = 1; incd = 1; ida = 3; dec = 0; cyc(); idle();
    chk("coll_r3", int'(db), 8'h10);
    chk("coll_flags", int'({zf, nf, cf}), 3'b011);
    // Different indices: both execute.
    sba = 2; dba = 3; dbi = 8'h10; dbld = 1; incd = 1; ida = 2; dec = 0; cyc(); idle();
    chk("both_r3", int'(db), 8'h10);
    chk("both_r2", int'(sb), 8'h00);
    chk("both_flags", int'({zf, nf, cf}), 3'b101);

    // Back-to-back increments on r1: A5 -> A8.
    sba = 1;
    for (int i = 0; i < 3; i++) begin
      incd = 1; ida = 1; dec = 0; cyc();
    end
    idle();
    chk("b2b_r1", int'(sb), 8'hA8);
    chk("b2b_flags", int'({zf, nf, cf}), 3'b010);

    // Address register wrap, then load-suppresses-increment.
    dbi = 8'hFF; arll = 1; arhl = 1; cyc(); idle();
    chk("ar_ff", int'({adh, adl}), 16'hFFFF);
    arinc = 1; cyc(); idle();
    chk("ar_wrap_val", int'({adh, adl}), 16'h0000);
    chk("ar_wrap_flag", int'(arwrap), 1);
    cyc();
    chk("ar_wrap_clr", int'(arwrap), 0);
    dbi = 8'h34; arhl = 1; cyc(); idle();
    dbi = 8'h12; arll = 1; arinc = 1; cyc(); idle();
    chk("ar_ld_noinc", int'({adh, adl}), 16'h3412);
    arinc = 1; cyc(); idle();
    chk("ar_inc", int'({adh, adl}), 16'h3413);
    dbi = 8'hFF; arll = 1; cyc(); idle();
    arinc = 1; cyc(); idle();
    chk("ar_carry", int'({adh, adl}), 16'h3500);
    chk("ar_carry_nowrap", int'(arwrap), 0);

    // Asynchronous reset between edges.
    #1 rst = 0;
    model_reset();
    #1;
    chk("arst_db", int'(db), 8'h00);
    chk("arst_sb", int'(sb), 8'h00);
    chk("arst_ar", int'({adh, adl}), 16'h0000);
    chk("arst_flags", int'({zf, nf, cf}), 0);
    @(negedge clk); #1 rst = 1;
    dba = 0; dbi = 8'h5A; dbld = 1; cyc(); idle();
    chk("post_rst_wr", int'(db), 8'h5A);

    // Mixed traffic checked by the model every cycle.
    for (int i = 0; i < 60; i++) begin
      dbi   = 8'($urandom_range(0, 255));
      dba   = 2'($urandom_range(0, 3));
      sba   = 2'($urandom_range(0, 3));
      ida   = 2'($urandom_range(0, 3));
      dbld  = ($urandom_range(0, 3) == 0);
      incd  = ($urandom_range(0, 1) == 0);
      dec   = ($urandom_range(0, 1) == 0);
      arll  = ($urandom_range(0, 7) == 0);
      arhl  = ($urandom_range(0, 7) == 0);
      arinc = ($urandom_range(0, 1) == 0);
      cyc();
    end
    idle();
    cyc();
    cmp_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
